// File: rtl/ptw_pkg.sv
// rtl/ptw_pkg.sv - shared types and widths for the page-table-walker arbiter
package ptw_pkg;

  localparam int PTW_VA_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } ptw_state_e;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } ptw_src_e;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin pick; bit 0 is the I side, bit 1 the D side
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // last=1 means D won most recently, so I takes a tie
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ptw_arbiter.sv
// rtl/ptw_arbiter.sv - I/D arbiter and enable sequencer for the shared page-table walker
module ptw_arbiter
  import ptw_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [PTW_VA_W-1:0] i_va,
  output logic                i_ack,
  output logic [PTW_VA_W-1:0] i_pa,
  output logic                i_fault,
  input  logic                d_req,
  input  logic [PTW_VA_W-1:0] d_va,
  output logic                d_ack,
  output logic [PTW_VA_W-1:0] d_pa,
  output logic                d_fault,
  input  logic                flush,
  output logic                walk_en,
  output logic [PTW_VA_W-1:0] walk_va,
  input  logic                walk_done,
  input  logic [PTW_VA_W-1:0] walk_pa,
  input  logic                walk_valid,
  output logic                busy
);

  ptw_state_e          state_q;
  ptw_src_e            owner_q;
  ptw_src_e            last_q;
  logic                discard_q;
  logic                fault_q;
  logic [PTW_VA_W-1:0] va_q;
  logic [PTW_VA_W-1:0] pa_q;

  logic [1:0] gnt;
  logic       owner_req;
  logic       abort;
  logic       ack_ok;

  rr_pick2 u_pick (
    .req  ({d_req, i_req}),
    .last (last_q == SRC_D),
    .gnt  (gnt)
  );

  assign owner_req = (owner_q == SRC_I) ? i_req : d_req;
  assign abort     = flush | ~owner_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= SRC_I;
      last_q    <= SRC_D;
      discard_q <= 1'b0;
      fault_q   <= 1'b0;
      va_q      <= '0;
      pa_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!flush && gnt != 2'b00) begin
            owner_q   <= ptw_src_e'(gnt[1]);
            last_q    <= ptw_src_e'(gnt[1]);
            va_q      <= gnt[1] ? d_va : i_va;
            discard_q <= 1'b0;
            state_q   <= WALK;
          end
        end
        WALK: begin
          // The walker cannot be cancelled, so an abort only marks the result as unwanted
          if (walk_done) begin
            pa_q    <= walk_pa;
            fault_q <= ~walk_valid;
            state_q <= RESP;
            if (abort) discard_q <= 1'b1;
          end else if (abort) begin
            discard_q <= 1'b1;
            state_q   <= DRAIN;
          end
        end
        DRAIN: begin
          if (walk_done) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          discard_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign ack_ok  = (state_q == RESP) && !discard_q && !flush;
  assign i_ack   = ack_ok && (owner_q == SRC_I);
  assign d_ack   = ack_ok && (owner_q == SRC_D);
  assign i_pa    = pa_q;
  assign d_pa    = pa_q;
  assign i_fault = fault_q;
  assign d_fault = fault_q;
  assign walk_en = (state_q == WALK) || (state_q == DRAIN);
  assign walk_va = va_q;
  assign busy    = (state_q != IDLE);

endmodule
